calc_op_sequencer: RTL and testbench

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

---
 rtl/calc_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: button-driven stack/queue calculator command sequencer.
// Define SEQ_TIMEOUT_EN to add a mem_ack timeout (TMO_CYC cycles) into ERR.
module calc_op_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stack_queue,
    input  logic [4:0]  btns,
    input  logic [15:0] switches,
    output logic        mem_req,
    output logic        mem_op,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_y,
    output logic [31:0] disp,
    output logic [4:0]  count,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {
        IDLE, PUSH_SW, POP_1, POP_2, EXEC, PUSH_Y, ERR
    } state_t;

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    state_t     state, state_nx;
    logic [4:0] btns_q;
    logic [4:0] rise;
    logic       armed;
    logic [3:0] op_q;
    logic [3:0] op_sel;
    logic       mode_q;
    logic       accept;
    logic       xfer;
    logic       tmo;

    // armed masks the first cycle after reset so a held button is not an edge
    assign rise    = armed ? (btns & ~btns_q) : 5'd0;
    assign accept  = (state == IDLE) && (rise != 5'd0);
    assign mem_req = state inside {PUSH_SW, POP_1, POP_2, PUSH_Y};
    assign mem_op  = (state == PUSH_SW) || (state == PUSH_Y);
    assign xfer    = mem_req && mem_ack;
    assign alu_op  = (state == EXEC) ? op_q : 4'b0000;
    assign busy    = (state != IDLE) && (state != ERR);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (!mem_req || mem_ack)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo = mem_req && !mem_ack && (tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        op_sel = 4'b0000;
        priority case (1'b1)
            rise[1]: op_sel = 4'b0001;
            rise[2]: op_sel = 4'b0010;
            rise[3]: op_sel = 4'b0100;
            rise[4]: op_sel = 4'b1000;
            default: op_sel = 4'b0000;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (rise[0])
                        state_nx = (count < DEPTH_C) ? PUSH_SW : ERR;
                    else
                        state_nx = (count >= 5'd2) ? POP_1 : ERR;
                end
            end
            PUSH_SW, PUSH_Y: begin
                if (tmo)
                    state_nx = ERR;
                else if (mem_ack)
                    state_nx = IDLE;
            end
            POP_1: begin
                if (tmo)
                    state_nx = ERR;
                else if (mem_ack)
                    state_nx = POP_2;
            end
            POP_2: begin
                if (tmo)
                    state_nx = ERR;
                else if (mem_ack)
                    state_nx = EXEC;
            end
            EXEC:    state_nx = PUSH_Y;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            btns_q    <= 5'd0;
            armed     <= 1'b0;
            op_q      <= 4'b0000;
            mode_q    <= 1'b0;
            mem_wdata <= 32'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            disp      <= 32'd0;
            count     <= 5'd0;
            err       <= 1'b0;
        end else begin
            state  <= state_nx;
            btns_q <= btns;
            armed  <= 1'b1;
            if (accept) begin
                op_q   <= op_sel;
                mode_q <= stack_queue;
                err    <= (state_nx == ERR);
                if (rise[0])
                    mem_wdata <= {16'd0, switches};
            end
            if (tmo)
                err <= 1'b1;
            if (state == EXEC)
                mem_wdata <= alu_y;
            // stack pops the top (B) first, queue pops the oldest (A) first
            if (xfer) begin
                unique case (state)
                    PUSH_SW, PUSH_Y: begin
                        count <= count + 5'd1;
                        disp  <= mem_wdata;
                    end
                    POP_1: begin
                        count <= count - 5'd1;
                        if (mode_q)
                            alu_b <= mem_rdata;
                        else
                            alu_a <= mem_rdata;
                    end
                    POP_2: begin
                        count <= count - 5'd1;
                        if (mode_q)
                            alu_a <= mem_rdata;
                        else
                            alu_b <= mem_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: memory responder, ALU and reference model.
// Random command streams are compared against a queue-based model of the stack.
module tb_calc_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stack_queue = 1'b1;
    logic [4:0]  btns = 5'd0;
    logic [15:0] switches = 16'd0;
    logic        mem_req;
    logic        mem_op;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_y;
    logic [31:0] disp;
    logic [4:0]  count;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_disp = 32'd0;
    logic        exp_err = 1'b0;

    int ack_max  = 0;
    int ack_wait = 0;
    int wcnt     = 0;
    bit ack_off  = 1'b0;
    bit stray    = 1'b0;

    calc_op_sequencer dut (
        .clk(clk), .rst(rst), .stack_queue(stack_queue),
        .btns(btns), .switches(switches),
        .mem_req(mem_req), .mem_op(mem_op), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .disp(disp), .count(count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0100: return a ^ b;
            4'b1000: return a | b;
            default: return 32'hDEAD_0000;
        endcase
    endfunction

    assign alu_y = alu_f(alu_a, alu_b, alu_op);

    // Memory: decisions at negedge, transfers committed at posedge
    always @(clk) begin
        logic [31:0] tmp;
        if (!clk) begin
            if (mem_req) begin
                mem_ack = !ack_off && (wcnt >= ack_wait);
                if (!mem_op && mem_q.size() > 0)
                    mem_rdata = stack_queue ? mem_q[mem_q.size()-1] : mem_q[0];
                wcnt++;
            end else begin
                mem_ack = stray;
                wcnt = 0;
            end
        end else if (mem_req && mem_ack) begin
            if (mem_op)
                mem_q.push_back(mem_wdata);
            else if (mem_q.size() > 0) begin
                if (stack_queue) tmp = mem_q.pop_back();
                else tmp = mem_q.pop_front();
            end
            wcnt = 0;
            ack_wait = $urandom_range(ack_max, 0);
        end
    end

    task automatic model_cmd(input logic [4:0] b);
        logic [31:0] a, bb, y;
        logic [3:0]  op;
        if (b[0]) begin
            if (exp_q.size() >= 16) exp_err = 1'b1;
            else begin
                exp_q.push_back({16'd0, switches});
                exp_disp = {16'd0, switches};
                exp_err = 1'b0;
            end
        end else if (b[4:1] != 4'd0) begin
            op = 4'd0;
            for (int i = 4; i >= 1; i--)
                if (b[i]) op = 4'b0001 << (i - 1);
            if (exp_q.size() < 2) exp_err = 1'b1;
            else begin
                if (stack_queue) begin
                    bb = exp_q.pop_back();
                    a  = exp_q.pop_back();
                end else begin
                    a  = exp_q.pop_front();
                    bb = exp_q.pop_front();
                end
                y = alu_f(a, bb, op);
                exp_q.push_back(y);
                exp_disp = y;
                exp_err = 1'b0;
            end
        end
    endtask

    task automatic cmd(input logic [4:0] b);
        int n;
        @(negedge clk);
        btns = b;
        @(posedge clk); #1;
        btns = 5'd0;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: busy still %0b after %0d cycles, required 0", busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        btns = 5'd0;
        mem_q.delete();
        exp_q.delete();
        exp_disp = 32'd0;
        exp_err = 1'b0;
        ack_wait = 0;
        ack_max = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({mem_req, mem_op, mem_wdata, alu_a, alu_b, alu_op, disp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b op=%0b wd=%h a=%h b=%h aop=%h disp=%h, required all 0",
                     mem_req, mem_op, mem_wdata, alu_a, alu_b, alu_op, disp);
        end
        checks++;
        if ({count, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_status: count=%0d busy=%0b err=%0b, required 0", count, busy, err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_push_latency;
        stack_queue = 1'b1;
        ack_max = 0; ack_wait = 0;
        switches = 16'h0005;
        model_cmd(5'b00001);
        @(negedge clk);
        btns = 5'b00001;
        @(posedge clk); #1;
        btns = 5'd0;
        checks++;
        if ({busy, mem_req, mem_op, mem_wdata} !== {3'b111, 32'h5}) begin
            errors++;
            $display("FAIL push_sw: busy=%0b req=%0b op=%0b wd=%h, required 1 1 1 00000005",
                     busy, mem_req, mem_op, mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({count, disp, mem_wdata} !== {5'd1, 32'h5, 32'h5}) begin
            errors++;
            $display("FAIL push_done: count=%0d disp=%h wd=%h, required 1 00000005 00000005",
                     count, disp, mem_wdata);
        end
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL push_idle: busy=%0b req=%0b, required 0 0", busy, mem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op_exact(input logic [4:0] b, input logic [3:0] op,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ey);
        ack_max = 0; ack_wait = 0;
        model_cmd(b);
        @(negedge clk);
        btns = b;
        @(posedge clk); #1;
        btns = 5'd0;
        checks++;
        if ({mem_req, mem_op, alu_op} !== {2'b10, 4'b0000}) begin
            errors++;
            $display("FAIL pop1: req=%0b op=%0b alu_op=%b, required 1 0 0000", mem_req, mem_op, alu_op);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({alu_a, alu_b, alu_op, mem_req} !== {ea, eb, op, 1'b0}) begin
            errors++;
            $display("FAIL exec: a=%h b=%h op=%b req=%0b, required %h %h %b 0",
                     alu_a, alu_b, alu_op, mem_req, ea, eb, op);
        end
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_op, mem_wdata, alu_op} !== {2'b11, ey, 4'b0000}) begin
            errors++;
            $display("FAIL push_y: req=%0b op=%0b wd=%h alu_op=%b, required 1 1 %h 0000",
                     mem_req, mem_op, mem_wdata, alu_op, ey);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, count, disp} !== {1'b0, 5'(exp_q.size()), exp_disp}) begin
            errors++;
            $display("FAIL op_done: busy=%0b count=%0d disp=%h, required 0 %0d %h",
                     busy, count, disp, exp_q.size(), exp_disp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_op_stack;
        stack_queue = 1'b1;
        switches = 16'd7; model_cmd(5'b00001); cmd(5'b00001);
        switches = 16'd3; model_cmd(5'b00001); cmd(5'b00001);
        run_op_exact(5'b00010, 4'b0001, 32'd7, 32'd3, 32'd10);
    endtask

    task automatic test_op_queue;
        do_reset;
        stack_queue = 1'b0;
        switches = 16'd7; model_cmd(5'b00001); cmd(5'b00001);
        switches = 16'd3; model_cmd(5'b00001); cmd(5'b00001);
        run_op_exact(5'b00100, 4'b0010, 32'd7, 32'd3, 32'd4);
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL queue_count: count=%0d, required 1", count);
        end
    endtask

    task automatic test_errors;
        model_cmd(5'b01000);
        @(negedge clk);
        btns = 5'b01000;
        @(posedge clk); #1;
        btns = 5'd0;
        checks++;
        if ({err, mem_req, busy} !== 3'b100) begin
            errors++;
            $display("FAIL op_underflow: err=%0b req=%0b busy=%0b, required 1 0 0", err, mem_req, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({err, count} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL err_sticky: err=%0b count=%0d, required 1 1", err, count);
        end
        ack_max = 2;
        while (exp_q.size() < 16) begin
            switches = 16'($urandom);
            model_cmd(5'b00001);
            cmd(5'b00001);
        end
        checks++;
        if ({err, count} !== {1'b0, 5'd16}) begin
            errors++;
            $display("FAIL fill: err=%0b count=%0d, required 0 16", err, count);
        end
        model_cmd(5'b00001);
        @(negedge clk);
        btns = 5'b00001;
        @(posedge clk); #1;
        btns = 5'd0;
        checks++;
        if ({err, mem_req, count} !== {2'b10, 5'd16}) begin
            errors++;
            $display("FAIL push_overflow: err=%0b req=%0b count=%0d, required 1 0 16", err, mem_req, count);
        end
        @(posedge clk); #1;
        model_cmd(5'b10000);
        cmd(5'b10000);
        checks++;
        if ({err, count, disp} !== {exp_err, 5'(exp_q.size()), exp_disp}) begin
            errors++;
            $display("FAIL err_clear: err=%0b count=%0d disp=%h, required %0b %0d %h",
                     err, count, disp, exp_err, exp_q.size(), exp_disp);
        end
    endtask

    task automatic test_simul_busy;
        int n;
        do_reset;
        stack_queue = 1'b1;
        switches = 16'd20; model_cmd(5'b00001); cmd(5'b00001);
        switches = 16'd9;  model_cmd(5'b01001); cmd(5'b01001);
        checks++;
        if ({count, disp, alu_a} !== {5'd2, 32'd9, 32'd0}) begin
            errors++;
            $display("FAIL simultaneous: count=%0d disp=%h alu_a=%h, required 2 00000009 00000000",
                     count, disp, alu_a);
        end
        ack_max = 1;
        model_cmd(5'b00010);
        @(negedge clk);
        btns = 5'b00010;
        @(posedge clk); #1;
        btns = 5'd0;
        @(negedge clk);
        btns = 5'b00001;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({count, disp, busy} !== {5'(exp_q.size()), exp_disp, 1'b0}) begin
            errors++;
            $display("FAIL busy_drop: count=%0d disp=%h busy=%0b, required %0d %h 0",
                     count, disp, busy, exp_q.size(), exp_disp);
        end
        btns = 5'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_pop;
        bit saw_req;
        stack_queue = 1'b1;
        ack_max = 0; ack_wait = 0;
        switches = 16'd4; model_cmd(5'b00001); cmd(5'b00001);
        @(negedge clk);
        btns = 5'b00010;
        @(posedge clk); #1;
        btns = 5'd0;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_op} !== 2'b10) begin
            errors++;
            $display("FAIL pop2_state: req=%0b op=%0b, required 1 0", mem_req, mem_op);
        end
        rst = 1'b0;
        btns = 5'b00001;
        #1;
        checks++;
        if ({mem_req, mem_op, mem_wdata, alu_a, alu_b, alu_op, disp, count, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_pop: req=%0b a=%h b=%h disp=%h count=%0d busy=%0b",
                     mem_req, alu_a, alu_b, disp, count, busy);
        end
        mem_q.delete();
        exp_q.delete();
        exp_disp = 32'd0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        saw_req = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mem_req || busy) saw_req = 1'b1;
        end
        checks++;
        if ({saw_req, count} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL held_through_reset: saw_req=%0b count=%0d, required 0 0", saw_req, count);
        end
        btns = 5'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [4:0] b;
        bit ok;
        for (int it = 0; it < 80; it++) begin
            stack_queue = 1'($urandom);
            stray = 1'($urandom_range(3, 0) == 0);
            ack_max = $urandom_range(3, 0);
            switches = 16'($urandom);
            b = (it % 3 == 0) ? 5'b00001 : 5'($urandom_range(31, 1));
            model_cmd(b);
            cmd(b);
            checks++;
            if ({count, disp, err} !== {5'(exp_q.size()), exp_disp, exp_err}) begin
                errors++;
                $display("FAIL random_state[%0d]: count=%0d disp=%h err=%0b, required %0d %h %0b",
                         it, count, disp, err, exp_q.size(), exp_disp, exp_err);
            end
            ok = (mem_q.size() == exp_q.size());
            if (ok)
                foreach (exp_q[i])
                    if (mem_q[i] !== exp_q[i]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_mem[%0d]: memory size %0d contents differ, required size %0d",
                         it, mem_q.size(), exp_q.size());
            end
        end
        stray = 1'b0;
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        do_reset;
        ack_off = 1'b1;
        switches = 16'd1;
        @(negedge clk);
        btns = 5'b00001;
        @(posedge clk); #1;
        btns = 5'd0;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ({n, err, mem_req, count} !== {32'd255, 2'b10, 5'd0}) begin
            errors++;
            $display("FAIL timeout: cycles=%0d err=%0b req=%0b count=%0d, required 255 1 0 0",
                     n, err, mem_req, count);
        end
        ack_off = 1'b0;
        exp_err = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_push_latency;
        test_op_stack;
        test_op_queue;
        test_errors;
        test_simul_busy;
        test_reset_mid_pop;
        test_random;
`ifdef SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
